// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared encodings for the ALU operand-select pipeline stage.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Operand B source encoding carried on ALUsrc
    localparam logic [1:0] ALUSRC_REG   = 2'd0;
    localparam logic [1:0] ALUSRC_SEXT  = 2'd1;
    localparam logic [1:0] ALUSRC_ZEXT  = 2'd2;
    localparam logic [1:0] ALUSRC_UPPER = 2'd3;

    // Forward-select value meaning "take the register-file word"
    localparam int FWD_SEL_RF = 0;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_operand_select.sv
// ============================================================================
//  Module      : alu_operand_select
//  Description : Combinational operand A/B selection with immediate extension.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_operand_select
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMM_W     = 16,
    parameter int FWD_PORTS = 2
) (
    input  logic [WIDTH-1:0]                 read_data1_i,
    input  logic [WIDTH-1:0]                 read_data2_i,
    input  logic [IMM_W-1:0]                 imm_i,
    input  logic [1:0]                       alusrc_i,
    input  logic [$clog2(FWD_PORTS+1)-1:0]   fwd_sel_a_i,
    input  logic [$clog2(FWD_PORTS+1)-1:0]   fwd_sel_b_i,
    input  logic [FWD_PORTS*WIDTH-1:0]       fwd_data_i,
    output logic [WIDTH-1:0]                 op_a_o,
    output logic [WIDTH-1:0]                 op_b_o
);

    localparam int SEL_W = $clog2(FWD_PORTS + 1);
    localparam int EXT_W = WIDTH - IMM_W;

    logic [WIDTH-1:0] w_fwd_words [FWD_PORTS];
    logic [WIDTH-1:0] w_b_reg;

    for (genvar g = 0; g < FWD_PORTS; g++) begin : g_fwd_unpack
        assign w_fwd_words[g] = fwd_data_i[g*WIDTH +: WIDTH];
    end

    // Out-of-range selects match no forwarding word and fall back to the register file.
    always_comb begin
        op_a_o  = read_data1_i;
        w_b_reg = read_data2_i;
        for (int k = 0; k < FWD_PORTS; k++) begin
            if (fwd_sel_a_i == SEL_W'(k + 1 + FWD_SEL_RF)) begin
                op_a_o = w_fwd_words[k];
            end
            if (fwd_sel_b_i == SEL_W'(k + 1 + FWD_SEL_RF)) begin
                w_b_reg = w_fwd_words[k];
            end
        end
    end

    always_comb begin
        op_b_o = w_b_reg;
        case (alusrc_i)
            ALUSRC_REG:   op_b_o = w_b_reg;
            ALUSRC_SEXT:  op_b_o = {{EXT_W{imm_i[IMM_W-1]}}, imm_i};
            ALUSRC_ZEXT:  op_b_o = {{EXT_W{1'b0}}, imm_i};
            ALUSRC_UPPER: op_b_o = {imm_i, {EXT_W{1'b0}}};
            default:      op_b_o = w_b_reg;
        endcase
    end

endmodule : alu_operand_select

`default_nettype wire

// File: rtl/alu_operand_pipe.sv
// ============================================================================
//  Module      : alu_operand_pipe
//  Description : Registered valid/ready operand stage in front of the ALU.
//                Define ALU_OPERAND_SKID_EN for a 2-entry skid buffer that
//                removes the combinational out_ready -> in_ready path.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_operand_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IMM_W     = 16,
    parameter int FWD_PORTS = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 read_data1,
    input  logic [WIDTH-1:0]                 read_data2,
    input  logic [IMM_W-1:0]                 imm,
    input  logic [1:0]                       ALUsrc,
    input  logic [$clog2(FWD_PORTS+1)-1:0]   fwd_sel_a,
    input  logic [$clog2(FWD_PORTS+1)-1:0]   fwd_sel_b,
    input  logic [FWD_PORTS*WIDTH-1:0]       fwd_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 op_a,
    output logic [WIDTH-1:0]                 op_b
);

    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_accept;
    logic             w_consume;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] op_a_q,  op_a_d;
    logic [WIDTH-1:0] op_b_q,  op_b_d;

    alu_operand_select #(
        .WIDTH     (WIDTH),
        .IMM_W     (IMM_W),
        .FWD_PORTS (FWD_PORTS)
    ) u_select (
        .read_data1_i (read_data1),
        .read_data2_i (read_data2),
        .imm_i        (imm),
        .alusrc_i     (ALUsrc),
        .fwd_sel_a_i  (fwd_sel_a),
        .fwd_sel_b_i  (fwd_sel_b),
        .fwd_data_i   (fwd_data),
        .op_a_o       (w_sel_a),
        .op_b_o       (w_sel_b)
    );

    assign w_accept  = in_valid && in_ready;
    assign w_consume = valid_q && out_ready;

`ifdef ALU_OPERAND_SKID_EN

    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_a_q,     skid_a_d;
    logic [WIDTH-1:0] skid_b_q,     skid_b_d;

    // Ready depends only on the skid flop; reset and flush merely gate it.
    assign in_ready = rst_n && !flush && !skid_valid_q;

    always_comb begin
        valid_d      = valid_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        skid_valid_d = skid_valid_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid is only ever full behind a full output register; drain it first.
            if (out_ready) begin
                valid_d      = 1'b1;
                op_a_d       = skid_a_q;
                op_b_d       = skid_b_q;
                skid_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            if (!valid_q || out_ready) begin
                valid_d = 1'b1;
                op_a_d  = w_sel_a;
                op_b_d  = w_sel_b;
            end else begin
                skid_valid_d = 1'b1;
                skid_a_d     = w_sel_a;
                skid_b_d     = w_sel_b;
            end
        end else if (w_consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_valid_q <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
        end
    end

`else

    assign in_ready = rst_n && !flush && (!valid_q || out_ready);

    always_comb begin
        valid_d = valid_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            valid_d = 1'b1;
            op_a_d  = w_sel_a;
            op_b_d  = w_sel_b;
        end else if (w_consume) begin
            valid_d = 1'b0;
        end
    end

`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            valid_q <= valid_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
        end
    end

    assign out_valid = valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;

endmodule : alu_operand_pipe

`default_nettype wire

// File: tb/tb_alu_operand_pipe.sv
// ============================================================================
//  Module      : tb_alu_operand_pipe
//  Description : Directed self-checking bench for alu_operand_pipe.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [15:0] imm;
    logic [1:0]  ALUsrc;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [63:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;

    int checks = 0;
    int errors = 0;

    alu_operand_pipe #(
        .WIDTH     (32),
        .IMM_W     (16),
        .FWD_PORTS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .imm        (imm),
        .ALUsrc     (ALUsrc),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b),
        .fwd_data   (fwd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_a       (op_a),
        .op_b       (op_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        read_data1 = 32'hDEAD_BEEF;
        read_data2 = 32'hCAFE_F00D;
        imm        = 16'h1234;
        ALUsrc     = 2'd0;
        fwd_sel_a  = 2'd0;
        fwd_sel_b  = 2'd0;
        fwd_data   = 64'h0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
        end
        checks++;
        if (op_a !== 32'h0) begin
            errors++; $display("FAIL reset_op_a: got %h expected 00000000", op_a);
        end
        checks++;
        if (op_b !== 32'h0) begin
            errors++; $display("FAIL reset_op_b: got %h expected 00000000", op_b);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
    endtask

    task automatic test_reset_midflight();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        read_data1 = 32'h0000_0ABC;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || op_a !== 32'h0000_0ABC) begin
            errors++; $display("FAIL midreset_load: got v=%0b a=%h expected v=1 a=00000abc", out_valid, op_a);
        end
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || op_a !== 32'h0) begin
            errors++; $display("FAIL midreset_clear: got v=%0b a=%h expected v=0 a=00000000", out_valid, op_a);
        end
        tick();
    endtask

    task automatic test_modes();
        logic [31:0] exp_b [4];
        exp_b = '{32'h1234_5678, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000};
        read_data1 = 32'h1111_1111;
        read_data2 = 32'h1234_5678;
        imm        = 16'h8001;
        out_ready  = 1'b1;
        fwd_sel_a  = 2'd0;
        fwd_sel_b  = 2'd0;
        for (int m = 0; m < 4; m++) begin
            ALUsrc   = 2'(m);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || op_b !== exp_b[m]) begin
                errors++; $display("FAIL mode%0d_op_b: got v=%0b b=%h expected v=1 b=%h", m, out_valid, op_b, exp_b[m]);
            end
            checks++;
            if (op_a !== 32'h1111_1111) begin
                errors++; $display("FAIL mode%0d_op_a: got %h expected 11111111", m, op_a);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL modes_drain: got out_valid=%0b expected 0", out_valid);
        end
    endtask

    task automatic test_forwarding();
        read_data1 = 32'h1111_1111;
        read_data2 = 32'h2222_2222;
        fwd_data   = {32'h0000_BBBB, 32'hAAAA_0000};
        ALUsrc     = 2'd0;
        out_ready  = 1'b1;
        fwd_sel_a  = 2'd2;
        fwd_sel_b  = 2'd1;
        in_valid   = 1'b1;
        tick();
        checks++;
        if (op_a !== 32'h0000_BBBB || op_b !== 32'hAAAA_0000) begin
            errors++; $display("FAIL fwd_in_range: got a=%h b=%h expected a=0000bbbb b=aaaa0000", op_a, op_b);
        end
        fwd_sel_a = 2'd3;
        fwd_sel_b = 2'd3;
        tick();
        checks++;
        if (op_a !== 32'h1111_1111 || op_b !== 32'h2222_2222) begin
            errors++; $display("FAIL fwd_out_of_range: got a=%h b=%h expected a=11111111 b=22222222", op_a, op_b);
        end
        ALUsrc    = 2'd1;
        imm       = 16'h7FFF;
        fwd_sel_b = 2'd1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (op_b !== 32'h0000_7FFF) begin
            errors++; $display("FAIL fwd_ignored_imm: got %h expected 00007fff", op_b);
        end
        ALUsrc    = 2'd0;
        fwd_sel_a = 2'd0;
        fwd_sel_b = 2'd0;
        tick();
    endtask

    task automatic test_backpressure();
        int          send   = 1;
        int          expect_v = 1;
        logic        held_v = 1'b0;
        logic [31:0] held_a = '0;
        for (int c = 0; c < 40 && expect_v <= 8; c++) begin
            in_valid   = (send <= 8);
            read_data1 = 32'(send);
            out_ready  = !(c >= 4 && c <= 6);
            #1;
            if (held_v) begin
                checks++;
                if (out_valid !== 1'b1 || op_a !== held_a) begin
                    errors++; $display("FAIL bp_hold: got v=%0b a=%h expected v=1 a=%h", out_valid, op_a, held_a);
                end
            end
`ifdef ALU_OPERAND_SKID_EN
            if (c == 4) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL bp_skid_ready_first: got %0b expected 1", in_ready);
                end
            end
            if (c == 5) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_skid_ready_later: got %0b expected 0", in_ready);
                end
            end
`else
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready: got %0b expected 0 while stalled", in_ready);
                end
            end
`endif
            if (out_valid && out_ready) begin
                checks++;
                if (op_a !== 32'(expect_v)) begin
                    errors++; $display("FAIL bp_order: got %h expected %h", op_a, 32'(expect_v));
                end
                expect_v++;
            end
            held_v = out_valid && !out_ready;
            held_a = op_a;
            if (in_valid && in_ready) send++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (expect_v != 9 || send != 9) begin
            errors++; $display("FAIL bp_count: got sent=%0d received=%0d expected 8 and 8", send - 1, expect_v - 1);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_duplicate: got out_valid=%0b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        read_data1 = 32'h0000_0055;
        tick();
        read_data1 = 32'h0000_0066;
        tick();
        checks++;
        if (out_valid !== 1'b1 || op_a !== 32'h0000_0055) begin
            errors++; $display("FAIL flush_setup: got v=%0b a=%h expected v=1 a=00000055", out_valid, op_a);
        end
        flush      = 1'b1;
        read_data1 = 32'h0000_0077;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready: got %0b expected 0", in_ready);
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_dropped%0d: got out_valid=%0b a=%h expected 0", i, out_valid, op_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid   = 1'b1;
            read_data1 = 32'(100 + i);
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready%0d: got %0b expected 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || op_a !== 32'(100 + i)) begin
                errors++; $display("FAIL b2b_out%0d: got v=%0b a=%h expected v=1 a=%h", i, out_valid, op_a, 32'(100 + i));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: got %0b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_reset_midflight();
        test_modes();
        test_forwarding();
        test_backpressure();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_operand_pipe

`default_nettype wire
